ps2_rx_fifo: RTL and testbench



---
 rtl/ps2_rx_fifo_if.sv | 31 +++
 rtl/ps2_rx_fifo.sv | 126 ++++++++++++
 tb/tb_ps2_rx_fifo.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_rx_fifo_if.sv
// Consumer-side bus of the PS/2 receiver: scan-code FIFO read handshake plus status.
//   rd_data   : head byte of the FIFO
//   rd_valid  : FIFO non-empty
//   rd_ready  : consumer takes the head byte this cycle
//   ovf_clr   : clears the sticky overflow flag
//   overflow  : sticky, a good frame was dropped because the FIFO was full
//   frame_err : one-cycle pulse on a completed frame with bad parity or stop
//   count     : FIFO occupancy
interface ps2_rx_fifo_if #(
    parameter int unsigned FIFO_AW = 3
);
    logic [7:0]       rd_data;
    logic             rd_valid;
    logic             rd_ready;
    logic             ovf_clr;
    logic             overflow;
    logic             frame_err;
    logic [FIFO_AW:0] count;

    // Receiver side
    modport master (
        output rd_data, rd_valid, overflow, frame_err, count,
        input  rd_ready, ovf_clr
    );

    // Consumer side
    modport slave (
        input  rd_data, rd_valid, overflow, frame_err, count,
        output rd_ready, ovf_clr
    );
endinterface

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchronises the raw pins, deframes 11-bit frames
// (start, 8 data LSB first, odd parity, stop), and buffers good bytes in a FIFO.
//   clk, rst  : system clock, asynchronous active-high reset
//   ps2_clk   : raw PS/2 clock pin (asynchronous)
//   ps2_data  : raw PS/2 data pin (asynchronous)
//   bus       : FIFO read handshake and status (see ps2_rx_fifo_if)
module ps2_rx_fifo #(
    parameter int unsigned FIFO_AW = 3,
    parameter logic [15:0] TIMEOUT = 16'd50000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ps2_clk,
    input  logic          ps2_data,
    ps2_rx_fifo_if.master bus
);
    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam int unsigned PW    = FIFO_AW + 1;

    // Pin synchronisers; idle-high so reset values match an idle bus
    logic clk_s1, clk_s2, clk_hist;
    logic dat_s1, dat_s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_hist <= 1'b1;
            dat_s1   <= 1'b1;
            dat_s2   <= 1'b1;
        end else begin
            clk_s1   <= ps2_clk;
            clk_s2   <= clk_s1;
            clk_hist <= clk_s2;
            dat_s1   <= ps2_data;
            dat_s2   <= dat_s1;
        end
    end

    logic fall;
    assign fall = clk_hist & ~clk_s2;

    // Deframer state
    logic [3:0]  bit_cnt;
    logic [7:0]  shreg;
    logic        par_bit;
    logic [15:0] to_cnt;

    // Stop-bit edge: shreg and par_bit already hold the whole frame
    logic done, good;
    assign done = fall && (bit_cnt == 4'd10);
    assign good = (^{shreg, par_bit}) & dat_s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt <= 4'd0;
            shreg   <= 8'd0;
            par_bit <= 1'b0;
            to_cnt  <= 16'd0;
        end else if (fall) begin
            to_cnt <= 16'd0;
            case (bit_cnt)
                4'd0: if (!dat_s2) bit_cnt <= 4'd1;  // a high "start" is noise: stay put
                4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8: begin
                    shreg   <= {dat_s2, shreg[7:1]};
                    bit_cnt <= bit_cnt + 4'd1;
                end
                4'd9: begin
                    par_bit <= dat_s2;
                    bit_cnt <= 4'd10;
                end
                default: bit_cnt <= 4'd0;
            endcase
        end else if (bit_cnt != 4'd0) begin
            // Abandon a stalled partial frame without flagging an error
            if (to_cnt == TIMEOUT) begin
                bit_cnt <= 4'd0;
                to_cnt  <= 16'd0;
            end else begin
                to_cnt <= to_cnt + 16'd1;
            end
        end else begin
            to_cnt <= 16'd0;
        end
    end

    // FIFO with one extra pointer bit to tell full from empty
    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          full, empty, push, pop, ovf_set;
    logic          overflow_q, frame_err_q;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                     (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
    assign pop     = ~empty & bus.rd_ready;
    // A pop in the same cycle frees the slot a full FIFO needs
    assign push    = done & good & (~full | pop);
    assign ovf_set = done & good & full & ~pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= 8'd0;
        end else begin
            frame_err_q <= done & ~good;
            if (push) begin
                mem[wr_ptr[FIFO_AW-1:0]] <= shreg;
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            // Set has priority over clear
            if (ovf_set)          overflow_q <= 1'b1;
            else if (bus.ovf_clr) overflow_q <= 1'b0;
        end
    end

    assign bus.rd_data   = mem[rd_ptr[FIFO_AW-1:0]];
    assign bus.rd_valid  = ~empty;
    assign bus.count     = wr_ptr - rd_ptr;
    assign bus.overflow  = overflow_q;
    assign bus.frame_err = frame_err_q;
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Bench for ps2_rx_fifo: vector table, hand-written corner sequences, random frames.
module tb_ps2_rx_fifo;
    localparam int unsigned FIFO_AW = 3;
    localparam int          H       = 20;       // ps2_clk half period in system cycles
    localparam logic [15:0] TMO     = 16'd300;

    logic clk = 1'b0;
    logic rst, ps2_clk, ps2_data;

    always #5 clk = ~clk;

    ps2_rx_fifo_if #(.FIFO_AW(FIFO_AW)) bus ();

    ps2_rx_fifo #(.FIFO_AW(FIFO_AW), .TIMEOUT(TMO)) dut (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .bus      (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0] popped [$];
    int         err_cycles = 0;

    // Consumer-side monitor: records every accepted byte and every frame_err cycle
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (bus.rd_valid && bus.rd_ready) popped.push_back(bus.rd_data);
            if (bus.frame_err) err_cycles++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        popped.delete();
        err_cycles = 0;
    endtask

    task automatic drain();
        bus.rd_ready = 1'b1;
        wait_cyc(12);
        bus.rd_ready = 1'b0;
        wait_cyc(1);
    endtask

    task automatic check_popped(input string name, input logic [7:0] exp [$]);
        chk({name, " len"}, 32'(popped.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < popped.size(); i++)
            chk($sformatf("%s[%0d]", name, i), 32'(popped[i]), 32'(exp[i]));
    endtask

    // Drives the first nbits bits of a frame; pop_at_stop raises rd_ready only in
    // the cycle the stop-bit edge is detected (2 sync flops after the pin falls).
    task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop,
                              input int nbits, input bit pop_at_stop);
        logic [10:0] b;
        b = {~bad_stop, (~^d) ^ bad_par, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = b[i];
            wait_cyc(H);
            ps2_clk = 1'b0;
            if (pop_at_stop && i == 10) begin
                @(posedge clk);
                @(posedge clk);
                #1 bus.rd_ready = 1'b1;
                @(posedge clk);
                #1 bus.rd_ready = 1'b0;
                wait_cyc(H - 3);
            end else begin
                wait_cyc(H);
            end
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        if (nbits == 11) wait_cyc(2 * H);
    endtask

    typedef struct {
        logic [7:0] data;
        bit         bad_par;
        bit         bad_stop;
        bit         ready;
        bit         exp_valid;
        logic [7:0] exp_head;
        int         exp_count;
        int         exp_err;
        int         exp_npop;
    } vec_t;

    vec_t       tbl [8];
    logic [7:0] eq [$];
    logic [7:0] exp_q [$];
    int         exp_err;
    bit         rnd_run;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{8'h1C, 1'b0, 1'b0, 1'b0, 1'b1, 8'h1C, 1, 0, 0};
        tbl[1] = '{8'h1C, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 0, 1, 0};
        tbl[2] = '{8'h1C, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 0, 1, 0};
        tbl[3] = '{8'hF0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hF0, 1, 0, 0};
        tbl[4] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1, 0, 0};
        tbl[5] = '{8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 1, 0, 0};
        tbl[6] = '{8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 0, 1, 0};
        tbl[7] = '{8'hF0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 0, 0, 1};

        rst = 1'b1;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        bus.rd_ready = 1'b0;
        bus.ovf_clr = 1'b0;
        wait_cyc(3);
        chk("reset rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("reset rd_data", 32'(bus.rd_data), 32'd0);
        chk("reset count", 32'(bus.count), 32'd0);
        chk("reset overflow", 32'(bus.overflow), 32'd0);
        chk("reset frame_err", 32'(bus.frame_err), 32'd0);
        rst = 1'b0;
        wait_cyc(3);

        // Single frames from the table
        for (int v = 0; v < 8; v++) begin
            clear_mon();
            bus.rd_ready = tbl[v].ready;
            send_frame(tbl[v].data, tbl[v].bad_par, tbl[v].bad_stop, 11, 1'b0);
            bus.rd_ready = 1'b0;
            wait_cyc(1);
            chk($sformatf("vec%0d rd_valid", v), 32'(bus.rd_valid), 32'(tbl[v].exp_valid));
            chk($sformatf("vec%0d count", v), 32'(bus.count), 32'(tbl[v].exp_count));
            chk($sformatf("vec%0d frame_err cycles", v), 32'(err_cycles), 32'(tbl[v].exp_err));
            chk($sformatf("vec%0d pops", v), 32'(popped.size()), 32'(tbl[v].exp_npop));
            if (tbl[v].exp_valid)
                chk($sformatf("vec%0d head", v), 32'(bus.rd_data), 32'(tbl[v].exp_head));
            if (tbl[v].exp_npop > 0 && popped.size() > 0)
                chk($sformatf("vec%0d popped", v), 32'(popped[0]), 32'(tbl[v].data));
            drain();
        end

        // Back-to-back frames with the consumer always ready
        clear_mon();
        bus.rd_ready = 1'b1;
        send_frame(8'hF0, 1'b0, 1'b0, 11, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0, 11, 1'b0);
        bus.rd_ready = 1'b0;
        wait_cyc(1);
        eq.delete();
        eq.push_back(8'hF0);
        eq.push_back(8'h1C);
        check_popped("stream", eq);
        chk("stream count", 32'(bus.count), 32'd0);
        chk("stream frame_err", 32'(err_cycles), 32'd0);

        // Overflow: nine frames into an eight-deep FIFO
        clear_mon();
        eq.delete();
        for (int k = 1; k <= 9; k++) begin
            send_frame(8'(k), 1'b0, 1'b0, 11, 1'b0);
            if (k <= 8) eq.push_back(8'(k));
        end
        chk("ovf count", 32'(bus.count), 32'd8);
        chk("ovf overflow", 32'(bus.overflow), 32'd1);
        chk("ovf head", 32'(bus.rd_data), 32'h01);
        drain();
        check_popped("ovf drain", eq);
        chk("ovf sticky", 32'(bus.overflow), 32'd1);
        bus.ovf_clr = 1'b1;
        wait_cyc(1);
        bus.ovf_clr = 1'b0;
        wait_cyc(1);
        chk("ovf cleared", 32'(bus.overflow), 32'd0);

        // Full FIFO with a pop in the same cycle as the push
        clear_mon();
        eq.delete();
        for (int k = 0; k < 8; k++) begin
            send_frame(8'h11 + 8'(k), 1'b0, 1'b0, 11, 1'b0);
            eq.push_back(8'h11 + 8'(k));
        end
        eq.push_back(8'h19);
        chk("full count", 32'(bus.count), 32'd8);
        send_frame(8'h19, 1'b0, 1'b0, 11, 1'b1);
        chk("full push+pop count", 32'(bus.count), 32'd8);
        chk("full push+pop overflow", 32'(bus.overflow), 32'd0);
        chk("full push+pop popped", 32'(popped.size()), 32'd1);
        drain();
        check_popped("full drain", eq);

        // Stalled partial frame is abandoned after the timeout
        clear_mon();
        send_frame(8'h00, 1'b0, 1'b0, 5, 1'b0);
        wait_cyc(int'(TMO) + 100);
        send_frame(8'h3A, 1'b0, 1'b0, 11, 1'b0);
        chk("timeout count", 32'(bus.count), 32'd1);
        chk("timeout head", 32'(bus.rd_data), 32'h3A);
        chk("timeout frame_err", 32'(err_cycles), 32'd0);
        drain();

        // Reset in the middle of a frame
        clear_mon();
        send_frame(8'h77, 1'b0, 1'b0, 7, 1'b0);
        rst = 1'b1;
        wait_cyc(2);
        rst = 1'b0;
        wait_cyc(2);
        chk("midrst count", 32'(bus.count), 32'd0);
        send_frame(8'h45, 1'b0, 1'b0, 11, 1'b0);
        chk("midrst count after", 32'(bus.count), 32'd1);
        chk("midrst head", 32'(bus.rd_data), 32'h45);
        chk("midrst frame_err", 32'(err_cycles), 32'd0);
        drain();

        // Random frames, some corrupted, with a randomly stalling consumer
        clear_mon();
        exp_q.delete();
        exp_err = 0;
        rnd_run = 1'b1;
        fork
            begin
                for (int f = 0; f < 20; f++) begin
                    logic [7:0] d;
                    int         kind;
                    d    = 8'($urandom);
                    kind = int'($urandom_range(0, 3));
                    if (kind == 1 || kind == 2) exp_err++;
                    else exp_q.push_back(d);
                    send_frame(d, kind == 1, kind == 2, 11, 1'b0);
                end
                rnd_run = 1'b0;
            end
            begin
                while (rnd_run) begin
                    bus.rd_ready = 1'($urandom_range(0, 1));
                    wait_cyc(1);
                end
            end
        join
        drain();
        check_popped("random", exp_q);
        chk("random frame_err cycles", 32'(err_cycles), 32'(exp_err));
        chk("random overflow", 32'(bus.overflow), 32'd0);
        chk("random count", 32'(bus.count), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
